// File: rtl/lcd_console_pkg.sv
// Shared types and constants for the LCD console back-end.
// Holds state enums, the power-on command list and the delay helper.
package lcd_console_pkg;

    typedef enum logic [2:0] {
        E_IDLE,
        E_SETUP,
        E_HIGH,
        E_HOLD,
        E_EXEC
    } eng_state_t;

    typedef enum logic [1:0] {
        A_IDLE,
        A_POP,
        A_SEND,
        A_WAIT
    } adp_state_t;

    typedef enum logic [1:0] {
        I_PWR,
        I_SEND,
        I_WAIT,
        I_DONE
    } init_state_t;

    localparam logic [0:7][7:0] INIT_CMDS = {
        8'h38, 8'h38, 8'h38, 8'h38,
        8'h08, 8'h01, 8'h06, 8'h0C
    };

    localparam logic [31:0] SETUP_CYC = 32'd3;
    localparam logic [31:0] HIGH_CYC  = 32'd12;
    localparam logic [31:0] HOLD_CYC  = 32'd3;

    // ceil(ns * hz / 1e9), never less than one cycle
    function automatic logic [31:0] ns_to_cycles(
        input longint unsigned hz,
        input longint unsigned ns
    );
        longint unsigned c;
        c = (ns * hz + 64'd999_999_999) / 64'd1_000_000_000;
        if (c == 64'd0) c = 64'd1;
        return c[31:0];
    endfunction

endpackage

// File: rtl/lcd_fifo_console_seg7.sv
// Hex digit to active-low seven-segment code.
// Output order is {dp,g,f,e,d,c,b,a}.
module seg7_decoder
    import lcd_console_pkg::*;
(
    input  logic [3:0] hex,
    input  logic       dp_in,
    output logic [7:0] seg
);

    logic [7:0] code;

    // digit lookup; dp is overridden by dp_in
    always_comb begin
        code = 8'hFF;
        unique case (hex)
            4'h0: code = 8'hC0;
            4'h1: code = 8'hF9;
            4'h2: code = 8'hA4;
            4'h3: code = 8'hB0;
            4'h4: code = 8'h99;
            4'h5: code = 8'h92;
            4'h6: code = 8'h82;
            4'h7: code = 8'hF8;
            4'h8: code = 8'h80;
            4'h9: code = 8'h90;
            4'hA: code = 8'h88;
            4'hB: code = 8'h83;
            4'hC: code = 8'hC6;
            4'hD: code = 8'hA1;
            4'hE: code = 8'h86;
            4'hF: code = 8'h8E;
        endcase
    end

    assign seg = {dp_in, code[6:0]};

endmodule

// File: rtl/lcd_fifo_console.sv
// FIFO-fed HD44780 write engine with power-on init sequencer.
// Also shows the FIFO fill count on three hex digits.
module lcd_fifo_console
    import lcd_console_pkg::*;
#(
    parameter longint unsigned CLOCK_HZ = 64'd50_000_000
) (
    input  logic       MAX10_CLK1_50,
    input  logic       rst_n,
    input  logic       fifo_empty,
    input  logic [8:0] fifo_dout,
    output logic       fifo_rd_en,
    input  logic [9:0] fifo_count,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_e,
    output logic [7:0] lcd_data_o,
    input  logic [7:0] lcd_data_i,
    output logic       lcd_data_oe,
    output logic       init_done,
    output logic [7:0] hex_lo,
    output logic [7:0] hex_mid,
    output logic [7:0] hex_hi
);

    localparam logic [31:0] T_PWR   = ns_to_cycles(CLOCK_HZ, 64'd50_000_000);
    localparam logic [31:0] T_4100U = ns_to_cycles(CLOCK_HZ, 64'd4_100_000);
    localparam logic [31:0] T_100U  = ns_to_cycles(CLOCK_HZ, 64'd100_000);
    localparam logic [31:0] T_2M    = ns_to_cycles(CLOCK_HZ, 64'd2_000_000);
    localparam logic [31:0] T_40U   = ns_to_cycles(CLOCK_HZ, 64'd40_000);

    eng_state_t  e_state, e_next;
    init_state_t i_state, i_next;
    adp_state_t  a_state, a_next;

    logic [31:0] e_cnt, exec_cyc, exec_sel, p_cnt;
    logic [8:0]  eng_word, host_word, a_word, out_word;
    logic [2:0]  i_idx;
    logic        eng_valid, eng_go, host_valid, host_ready;
    logic        oe_q;
    logic        unused_bus;

    assign unused_bus = ^lcd_data_i;

    assign init_done  = (i_state == I_DONE);
    assign host_ready = init_done && (e_state == E_IDLE);
    assign host_word  = a_word;
    assign eng_valid  = init_done ? host_valid : (i_state == I_SEND);
    assign eng_word   = init_done ? host_word : {1'b0, INIT_CMDS[i_idx]};
    assign eng_go     = eng_valid && (e_state == E_IDLE);

    // exec delay: the first two init writes get the long reset waits
    always_comb begin
        exec_sel = T_40U;
        if (!init_done && i_idx == 3'd0)
            exec_sel = T_4100U;
        else if (!init_done && i_idx == 3'd1)
            exec_sel = T_100U;
        else if (!eng_word[8] && eng_word[7:2] == 6'd0 &&
                 eng_word[1:0] != 2'd0)
            exec_sel = T_2M;
    end

    // engine next state: each timed phase ends when e_cnt hits zero
    always_comb begin
        e_next = e_state;
        unique case (e_state)
            E_IDLE:  if (eng_go) e_next = E_SETUP;
            E_SETUP: if (e_cnt == 32'd0) e_next = E_HIGH;
            E_HIGH:  if (e_cnt == 32'd0) e_next = E_HOLD;
            E_HOLD:  if (e_cnt == 32'd0) e_next = E_EXEC;
            E_EXEC:  if (e_cnt == 32'd0) e_next = E_IDLE;
            default: e_next = E_IDLE;
        endcase
    end

    // engine state, phase counter and latched bus word
    always_ff @(posedge MAX10_CLK1_50 or negedge rst_n) begin
        if (!rst_n) begin
            e_state  <= E_IDLE;
            e_cnt    <= 32'd0;
            exec_cyc <= 32'd0;
            out_word <= 9'd0;
        end else begin
            e_state <= e_next;
            if (eng_go) begin
                out_word <= eng_word;
                exec_cyc <= exec_sel;
            end
            if (e_next != e_state) begin
                unique case (e_next)
                    E_SETUP: e_cnt <= SETUP_CYC - 32'd1;
                    E_HIGH:  e_cnt <= HIGH_CYC - 32'd1;
                    E_HOLD:  e_cnt <= HOLD_CYC - 32'd1;
                    E_EXEC:  e_cnt <= exec_cyc - 32'd1;
                    default: e_cnt <= 32'd0;
                endcase
            end else if (e_cnt != 32'd0) begin
                e_cnt <= e_cnt - 32'd1;
            end
        end
    end

    // init sequencer next state
    always_comb begin
        i_next = i_state;
        unique case (i_state)
            I_PWR:  if (p_cnt == T_PWR - 32'd1) i_next = I_SEND;
            I_SEND: if (eng_go) i_next = I_WAIT;
            I_WAIT:
                if (e_state == E_IDLE)
                    i_next = (i_idx == 3'd7) ? I_DONE : I_SEND;
            I_DONE: i_next = I_DONE;
            default: i_next = I_PWR;
        endcase
    end

    // init sequencer registers: power-on counter and command index
    always_ff @(posedge MAX10_CLK1_50 or negedge rst_n) begin
        if (!rst_n) begin
            i_state <= I_PWR;
            p_cnt   <= 32'd0;
            i_idx   <= 3'd0;
        end else begin
            i_state <= i_next;
            if (i_state == I_PWR) p_cnt <= p_cnt + 32'd1;
            if (i_state == I_WAIT && i_next == I_SEND)
                i_idx <= i_idx + 3'd1;
        end
    end

    // adapter next state and handshake outputs
    always_comb begin
        a_next     = a_state;
        host_valid = 1'b0;
        fifo_rd_en = 1'b0;
        unique case (a_state)
            A_IDLE:
                if (init_done && !fifo_empty && e_state == E_IDLE)
                    a_next = A_POP;
            A_POP: begin
                fifo_rd_en = 1'b1;
                a_next     = A_SEND;
            end
            A_SEND: begin
                host_valid = 1'b1;
                if (host_ready) a_next = A_WAIT;
            end
            A_WAIT: if (e_state == E_IDLE) a_next = A_IDLE;
            default: a_next = A_IDLE;
        endcase
    end

    // adapter state; head entry captured on entry to A_POP
    always_ff @(posedge MAX10_CLK1_50 or negedge rst_n) begin
        if (!rst_n) begin
            a_state <= A_IDLE;
            a_word  <= 9'd0;
        end else begin
            a_state <= a_next;
            if (a_state == A_IDLE && a_next == A_POP)
                a_word <= fifo_dout;
        end
    end

    // bus driver enables one cycle after reset release
    always_ff @(posedge MAX10_CLK1_50 or negedge rst_n) begin
        if (!rst_n) oe_q <= 1'b0;
        else        oe_q <= 1'b1;
    end

    assign lcd_e       = (e_state == E_HIGH);
    assign lcd_rs      = out_word[8];
    assign lcd_data_o  = out_word[7:0];
    assign lcd_rw      = 1'b0;
    assign lcd_data_oe = oe_q;

    seg7_decoder u_seg_lo (
        .hex   (fifo_count[3:0]),
        .dp_in (1'b1),
        .seg   (hex_lo)
    );

    seg7_decoder u_seg_mid (
        .hex   (fifo_count[7:4]),
        .dp_in (1'b1),
        .seg   (hex_mid)
    );

    seg7_decoder u_seg_hi (
        .hex   ({2'b00, fifo_count[9:8]}),
        .dp_in (1'b1),
        .seg   (hex_hi)
    );

endmodule

// File: tb/tb_lcd_fifo_console.sv
// Randomized bench for lcd_fifo_console against a write-level model.
// Runs with a 100 kHz clock rate so the init delays stay short.
module tb_lcd_fifo_console;

    // delays at 100 kHz: ceil(t * 1e5)
    localparam int T_PWR = 5000;
    localparam int T_41M = 410;
    localparam int T_100 = 10;
    localparam int T_2M  = 200;
    localparam int T_40  = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       fifo_empty, fifo_rd_en;
    logic [8:0] fifo_dout;
    logic [9:0] fifo_count;
    logic       lcd_rs, lcd_rw, lcd_e, lcd_data_oe, init_done;
    logic [7:0] lcd_data_o, hex_lo, hex_mid, hex_hi;
    logic [7:0] lcd_data_i = 8'h00;

    logic [8:0] fifo_mem [0:255];
    int         wr_ptr = 0;
    int         rd_ptr = 0;
    logic       seg_mode = 1'b0;
    logic [9:0] seg_val = 10'd0;

    int n_chk = 0;
    int n_pass = 0;

    logic [7:0] init_list [0:7] = '{8'h38, 8'h38, 8'h38, 8'h38,
                                    8'h08, 8'h01, 8'h06, 8'h0C};
    logic [7:0] seg_tbl [0:15] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0,
                                   8'h99, 8'h92, 8'h82, 8'hF8,
                                   8'h80, 8'h90, 8'h88, 8'h83,
                                   8'hC6, 8'hA1, 8'h86, 8'h8E};

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_dout  = fifo_mem[rd_ptr[7:0]];
    assign fifo_count = seg_mode ? seg_val : 10'(wr_ptr - rd_ptr);

    always #5 clk = ~clk;

    lcd_fifo_console #(.CLOCK_HZ(64'd100_000)) dut (
        .MAX10_CLK1_50 (clk),
        .rst_n         (rst_n),
        .fifo_empty    (fifo_empty),
        .fifo_dout     (fifo_dout),
        .fifo_rd_en    (fifo_rd_en),
        .fifo_count    (fifo_count),
        .lcd_rs        (lcd_rs),
        .lcd_rw        (lcd_rw),
        .lcd_e         (lcd_e),
        .lcd_data_o    (lcd_data_o),
        .lcd_data_i    (lcd_data_i),
        .lcd_data_oe   (lcd_data_oe),
        .init_done     (init_done),
        .hex_lo        (hex_lo),
        .hex_mid       (hex_mid),
        .hex_hi        (hex_hi)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // exec wait the spec assigns to a write (idx = init position, 8 = user)
    function automatic int exec_of(input logic [8:0] w, input int idx);
        if (idx == 0) return T_41M;
        if (idx == 1) return T_100;
        if (!w[8] && (w[7:0] == 8'h01 || w[7:0] == 8'h02 ||
                      w[7:0] == 8'h03))
            return T_2M;
        return T_40;
    endfunction

    // write-level monitor
    logic [8:0] pend_q[$];
    int         pend_cyc[$];
    int  cyc, wr_idx, rise_cyc, fall_cyc, prev_exec;
    int  last_pop, last_pop_exec, n_pops = 0;
    logic have_pop, e_prev, id_prev, rw_bad = 1'b0;
    logic [8:0] rise_val;

    always @(negedge clk) begin
        if (lcd_rw !== 1'b0) rw_bad = 1'b1;
        if (!rst_n) begin
            cyc = 0; wr_idx = 0; have_pop = 0;
            e_prev = 0; id_prev = 0;
            pend_q.delete(); pend_cyc.delete();
        end else begin
            cyc++;
            if (fifo_rd_en) begin
                chk("pop_after_init", init_done, 1);
                chk("pop_no_pending", pend_q.size(), 0);
                chk("pop_nonempty", wr_ptr != rd_ptr, 1);
                if (have_pop)
                    chk("pop_spacing",
                        cyc - last_pop >= 18 + last_pop_exec, 1);
                pend_q.push_back(fifo_mem[rd_ptr[7:0]]);
                pend_cyc.push_back(cyc);
                last_pop = cyc;
                last_pop_exec = exec_of(fifo_mem[rd_ptr[7:0]], 8);
                have_pop = 1;
                n_pops++;
                rd_ptr++;
            end
            if (lcd_e && !e_prev) begin
                logic [8:0] exp;
                exp = 9'h000;
                if (wr_idx < 8) begin
                    exp = {1'b0, init_list[wr_idx]};
                end else if (pend_q.size() > 0) begin
                    exp = pend_q.pop_front();
                    chk("pop_to_e",
                        (cyc - pend_cyc[0]) inside {[5:6]}, 1);
                    void'(pend_cyc.pop_front());
                end else begin
                    chk("spurious_write", 0, 1);
                end
                chk("wr_word", {lcd_rs, lcd_data_o}, exp);
                chk("init_flag", init_done, wr_idx >= 8);
                if (wr_idx == 0) chk("pwr_wait", cyc >= T_PWR, 1);
                else chk("write_gap", cyc - fall_cyc >= prev_exec + 6, 1);
                rise_cyc = cyc;
                rise_val = {lcd_rs, lcd_data_o};
                prev_exec = exec_of(exp, wr_idx);
                wr_idx++;
            end
            if (!lcd_e && e_prev) begin
                chk("e_width", cyc - rise_cyc, 12);
                chk("data_hold", {lcd_rs, lcd_data_o}, rise_val);
                fall_cyc = cyc;
            end
            if (init_done && !id_prev)
                chk("init_done_time", wr_idx == 8 && !lcd_e &&
                    cyc - fall_cyc >= 3 + prev_exec, 1);
            e_prev = lcd_e;
            id_prev = init_done;
        end
    end

    task automatic push(input logic [8:0] w);
        fifo_mem[wr_ptr[7:0]] = w;
        wr_ptr++;
    endtask

    task automatic wait_init();
        int n = 0;
        while (!init_done && n < 12000) begin
            @(negedge clk);
            n++;
        end
        chk("init_timeout", init_done, 1);
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((wr_ptr != rd_ptr || pend_q.size() != 0 || lcd_e) &&
               n < 8000) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", n < 8000, 1);
        repeat (300) @(negedge clk);
    endtask

    task automatic seg_check(input logic [9:0] v);
        seg_val = v;
        #1;
        chk("hex_lo", hex_lo, seg_tbl[v[3:0]]);
        chk("hex_mid", hex_mid, seg_tbl[v[7:4]]);
        chk("hex_hi", hex_hi, seg_tbl[{2'b00, v[9:8]}]);
    endtask

    task automatic rst_outputs(input string tag);
        chk({tag, "_e"}, lcd_e, 0);
        chk({tag, "_rs"}, lcd_rs, 0);
        chk({tag, "_rw"}, lcd_rw, 0);
        chk({tag, "_data"}, lcd_data_o, 0);
        chk({tag, "_oe"}, lcd_data_oe, 0);
        chk({tag, "_done"}, init_done, 0);
        chk({tag, "_rd"}, fifo_rd_en, 0);
    endtask

    initial begin
        int p0, n;
        logic [8:0] w;
        repeat (3) @(negedge clk);
        rst_outputs("reset");
        push(9'h141);
        @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("oe_on", lcd_data_oe, 1);
        wait_init();
        wait_drain();

        push(9'h001);
        push(9'h148);
        wait_drain();

        p0 = n_pops;
        for (int i = 0; i < 5; i++) push({1'b1, 8'($urandom_range(32, 126))});
        wait_drain();
        chk("burst_pops", n_pops - p0, 5);

        for (int i = 0; i < 10; i++) begin
            w[8] = 1'($urandom);
            w[7:0] = ($urandom % 3 == 0) ? 8'($urandom_range(1, 3))
                                         : 8'($urandom);
            push(w);
            if ($urandom % 4 == 0) repeat ($urandom_range(5, 60)) @(negedge clk);
        end
        wait_drain();

        push(9'h155);
        n = 0;
        while (!lcd_e && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("e_high_timeout", lcd_e, 1);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 rst_outputs("async_rst");
        repeat (4) @(negedge clk);
        #1 rst_n = 1'b1;
        wait_init();
        push(9'h17A);
        wait_drain();

        seg_mode = 1'b1;
        seg_check(10'h2A5);
        seg_check(10'h000);
        seg_check(10'h3FF);
        for (int i = 0; i < 6; i++) seg_check(10'($urandom));
        seg_mode = 1'b0;

        chk("rw_zero", rw_bad, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/lcd_fifo_console.md
# lcd_fifo_console

Display back-end between a 9-bit command/character FIFO and a write-only HD44780 16x2 character LCD on an 8-bit parallel bus. It runs the LCD power-on initialisation, then pops FIFO entries and writes each one as a command (rs=0) or a character (rs=1), using fixed execution delays. It also decodes the 10-bit FIFO fill count onto three active-low seven-segment digits.

## Interface
- CLOCK_HZ, 50_000_000: clock frequency; all delays derive from it.
- MAX10_CLK1_50  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low; clock MAX10_CLK1_50.
- fifo_empty  in  1  FIFO has no entries.
- fifo_dout  in  9  head entry: bit 8 = rs, bits 7:0 = data; first-word-fall-through, valid while !fifo_empty.
- fifo_rd_en  out  1  one-cycle pop strobe.
- fifo_count  in  10  FIFO fill level.
- lcd_rs  out  1  register select.
- lcd_rw  out  1  read/write; always 0.
- lcd_e  out  1  enable strobe.
- lcd_data_o  out  8  bus drive value.
- lcd_data_i  in  8  bus readback; unused (no busy-flag polling).
- lcd_data_oe  out  1  bus output enable.
- init_done  out  1  initialisation sequence complete.
- hex_lo, hex_mid, hex_hi  out  8 each  segments {dp,g,f,e,d,c,b,a}, active-low.

## Operation
- Write engine: accepts {rs,data} when host_valid && host_ready. host_ready is high only in IDLE after init_done.
- Engine states:
  - IDLE.
  - SETUP: 3 cycles (≥60 ns). Drive rs and data, lcd_e=0.
  - E_HIGH: 12 cycles (≥240 ns).
  - HOLD: 3 cycles, lcd_e=0, data held.
  - EXEC wait: 2 ms if rs=0 and data is 0x01, 0x02 or 0x03; otherwise 40 µs.
  - Then back to IDLE.
- Init sequence:
  - Wait 50 ms after reset release.
  - Write 0x38, wait 4.1 ms; write 0x38, wait 100 µs; write 0x38.
  - Write 0x38, 0x08, 0x01, 0x06, 0x0C, each with rs=0 and its normal EXEC wait.
  - After the 0x0C EXEC wait completes, set init_done=1. It stays 1 until reset.
- Adapter FSM:
  - A_IDLE → A_POP when init_done && !fifo_empty && the engine is idle. In A_POP, latch fifo_dout and pulse fifo_rd_en for exactly 1 cycle.
  - A_POP → A_SEND: hold host_valid high with the latched value until host_ready is seen.
  - A_SEND → A_WAIT: wait until the engine returns to IDLE, then go to A_IDLE.
- Exactly one pop per LCD write. No pop before init_done. No pop while a write is pending.
- lcd_data_oe: 0 in reset, 1 from the first cycle after reset release.
- Seven-segment outputs: hex_lo=count[3:0], hex_mid=count[7:4], hex_hi={2'b00,count[9:8]}. dp bit7=1 (off).
- Digit codes: 0=C0 1=F9 2=A4 3=B0 4=99 5=92 6=82 7=F8 8=80 9=90 A=88 b=83 C=C6 d=A1 E=86 F=8E.

## Timing
- Delay cycle counts = ceil(t·CLOCK_HZ), minimum 1 cycle. At 50 MHz: 50 ms=2_500_000, 4.1 ms=205_000, 2 ms=100_000, 100 µs=5_000, 40 µs=2_000.
- Reset values: lcd_e=0, lcd_rs=0, lcd_rw=0, lcd_data_o=0x00, lcd_data_oe=0, init_done=0, fifo_rd_en=0.
- Reset asserted mid-write or mid-init: all outputs return to reset values immediately (asynchronous). Init restarts with the full 50 ms wait after release.
- Data/rs are stable from SETUP start through HOLD end.
- Pop to E rising: 3 adapter cycles + 3 SETUP cycles.
- FIFO empties mid-stream: adapter idles in A_IDLE and resumes on the next !fifo_empty.
- Seven-segment outputs are combinational from fifo_count (0-cycle latency).

## Structure
- Package lcd_console_pkg holds:
  - engine and adapter state enums;
  - init command array {38,38,38,38,08,01,06,0C};
  - a delay-to-cycles constant function of CLOCK_HZ.
- Sub-module seg7_decoder: 4-bit hex + dp_in → 8-bit active-low code. Instantiated 3 times.
- Engine, init sequencer and adapter stay in the top file.

## Test plan
- Reset release, CLOCK_HZ=50e6 → first E rise with data 0x38, rs=0 at ≥2_500_000 cycles. Eight init writes follow with the specified gaps. init_done=1 after the 0x0C EXEC wait.
- Entry 0x141 queued before init_done → no fifo_rd_en before init_done. Afterwards one pop, then lcd_rs=1, lcd_data_o=0x41, E high 12 cycles.
- Entries 0x001 then 0x148 → gap from the 0x01 E-fall to the next E-rise is ≥100_000 cycles. The 0x48 write follows.
- Burst of 5 characters → exactly 5 fifo_rd_en pulses, spacing ≥2_018 cycles, lcd_rw=0 throughout.
- rst_n low during E_HIGH → lcd_e=0 and init_done=0 immediately. A full re-init follows release.
- fifo_count=0x2A5 → hex_lo=0x92, hex_mid=0x88, hex_hi=0xA4.
